// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch sequencer
package fetch_pkg;
  localparam int PC_W = 4;
  localparam int INSTR_W = 4;
  localparam int DEPTH = 2;
  localparam logic [INSTR_W-1:0] HALT_CODE = 4'b1111;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: small synchronous FIFO of fetched {pc, instr} entries; flush beats push/pop
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output logic [CW-1:0] count,
  output entry_t        head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rd];
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer feeding a 2-entry instruction buffer with redirect and halt
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PC_W = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int DEPTH = fetch_pkg::DEPTH,
  parameter logic [INSTR_W-1:0] HALT_CODE = fetch_pkg::HALT_CODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic               busy,
  output logic               halted,
  output logic [7:0]         fetch_count
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [7:0] fc;
  logic [CW-1:0] count;
  entry_t head;
  logic live, redir, go, pop, push;
  assign live = state == FETCH || state == DRAIN;
  assign redir = redirect_valid && live;
  assign go = start && !live;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready && !redir;
  assign push = state == FETCH && !redir && (count < CW'(DEPTH) || pop);
  always_comb begin
    state_n = state;
    pc_n = pc;
    if (go) begin
      state_n = FETCH;
      pc_n = start_pc;
    end else if (redir) begin
      state_n = FETCH;
      pc_n = redirect_pc;
    end else if (push) begin
      pc_n = pc + 1'b1;
      state_n = imem_instr == HALT_CODE ? DRAIN : FETCH;
    end else if (state == DRAIN && count == CW'(pop)) begin
      state_n = HALTED;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      fc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fc <= go ? '0 : (pop && fc != 8'hff) ? fc + 8'd1 : fc;
    end
  end
  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(go || redir),
    .din('{pc: pc, instr: imem_instr}),
    .count(count),
    .head(head)
  );
  assign imem_pc = pc;
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign busy = live;
  assign halted = state == HALTED;
  assign fetch_count = fc;
endmodule
